// File: rtl/pwm_fade_sequencer_if.sv
// Decoded register-write bus from the SPI front end into the PWM fade sequencer.
interface pwm_fade_sequencer_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_fade_sequencer.sv
// PWM configuration register bank with an autonomous duty-cycle fade engine.
// Host writes to the duty register always take priority over the fade engine.
module pwm_fade_sequencer #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pwm_fade_sequencer_if.slave         wr_bus,
  output logic [7:0]                  en_reg_out_7_0,
  output logic [7:0]                  en_reg_out_15_8,
  output logic [7:0]                  en_reg_pwm_7_0,
  output logic [7:0]                  en_reg_pwm_15_8,
  output logic [7:0]                  pwm_duty_cycle,
  output logic                        fade_busy,
  output logic                        fade_done
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [7:0]     en_out_lo_q, en_out_lo_d;
  logic [7:0]     en_out_hi_q, en_out_hi_d;
  logic [7:0]     en_pwm_lo_q, en_pwm_lo_d;
  logic [7:0]     en_pwm_hi_q, en_pwm_hi_d;
  logic [7:0]     duty_q, duty_d;
  logic [7:0]     target_q, target_d;
  logic [7:0]     step_q, step_d;
  logic [7:0]     period_q, period_d;
  logic [7:0]     origin_q, origin_d;
  logic           loop_q, loop_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     per_q, per_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           presc_wrap;
  logic           step_evt;
  logic           dir_up;
  logic [8:0]     tgt9, dut9, diff9, step9, next9;

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
  // >= keeps the period counter from running off if fade_period shrinks mid-run
  assign step_evt   = (state_q == RUN) && presc_wrap && (per_q >= period_q);

  assign tgt9   = {1'b0, target_q};
  assign dut9   = {1'b0, duty_q};
  assign dir_up = (tgt9 >= dut9);
  assign diff9  = dir_up ? (tgt9 - dut9) : (dut9 - tgt9);
  assign step9  = (step_q == 8'd0) ? 9'd1 : {1'b0, step_q};
  assign next9  = dir_up ? (dut9 + step9) : (dut9 - step9);

  always_comb begin
    state_d     = state_q;
    en_out_lo_d = en_out_lo_q;
    en_out_hi_d = en_out_hi_q;
    en_pwm_lo_d = en_pwm_lo_q;
    en_pwm_hi_d = en_pwm_hi_q;
    duty_d      = duty_q;
    target_d    = target_q;
    step_d      = step_q;
    period_d    = period_q;
    origin_d    = origin_q;
    loop_d      = loop_q;
    presc_d     = presc_q;
    per_d       = per_q;
    done_d      = 1'b0;

    if (state_q == RUN) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      if (presc_wrap) begin
        per_d = (per_q >= period_q) ? '0 : per_q + 1'b1;
      end
    end

    if (step_evt) begin
      if (diff9 <= step9) begin
        duty_d = target_q;
        done_d = 1'b1;
        if (loop_q) begin
          target_d = origin_q;
          origin_d = target_q;
        end else begin
          state_d = IDLE;
          presc_d = '0;
          per_d   = '0;
        end
      end else begin
        duty_d = next9[7:0];
      end
    end

    // Host writes are applied last so they override any coincident step result
    if (wr_bus.wr_valid) begin
      case (wr_bus.wr_addr)
        7'h00: en_out_lo_d = wr_bus.wr_data;
        7'h01: en_out_hi_d = wr_bus.wr_data;
        7'h02: en_pwm_lo_d = wr_bus.wr_data;
        7'h03: en_pwm_hi_d = wr_bus.wr_data;
        7'h04: begin
          duty_d   = wr_bus.wr_data;
          target_d = target_q;
          origin_d = origin_q;
          state_d  = IDLE;
          done_d   = 1'b0;
          presc_d  = '0;
          per_d    = '0;
        end
        7'h05: target_d = wr_bus.wr_data;
        7'h06: step_d   = wr_bus.wr_data;
        7'h07: period_d = wr_bus.wr_data;
        7'h08: begin
          duty_d   = duty_q;
          target_d = target_q;
          done_d   = 1'b0;
          presc_d  = '0;
          per_d    = '0;
          if (wr_bus.wr_data[0]) begin
            state_d  = RUN;
            origin_d = duty_q;
            loop_d   = wr_bus.wr_data[1];
          end else begin
            state_d  = IDLE;
            origin_d = origin_q;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      target_q    <= '0;
      step_q      <= '0;
      period_q    <= '0;
      origin_q    <= '0;
      loop_q      <= 1'b0;
      presc_q     <= '0;
      per_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_out_lo_q <= en_out_lo_d;
      en_out_hi_q <= en_out_hi_d;
      en_pwm_lo_q <= en_pwm_lo_d;
      en_pwm_hi_q <= en_pwm_hi_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_q      <= step_d;
      period_q    <= period_d;
      origin_q    <= origin_d;
      loop_q      <= loop_d;
      presc_q     <= presc_d;
      per_q       <= per_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign fade_busy       = busy_q;
  assign fade_done       = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer with PRESCALE=4; expected values are hand-computed.
module tb_pwm_fade_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       fade_busy, fade_done;
  int unsigned total;
  int unsigned bad;

  pwm_fade_sequencer_if bus ();

  pwm_fade_sequencer #(.PRESCALE(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_bus          (bus.slave),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .fade_busy       (fade_busy),
    .fade_done       (fade_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge and
  // the task returns at the negedge right after it.
  task automatic wr(input logic [6:0] addr, input logic [7:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_duty;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    cycles(2);
    check("rst_duty", pwm_duty_cycle, 8'h00);
    check("rst_en0", en_reg_out_7_0, 8'h00);
    check("rst_busy", fade_busy, 1'b0);
    check("rst_done", fade_done, 1'b0);
    rst_n = 1'b1;
    cycles(1);

    // Direct registers
    wr(7'h00, 8'hFF); check("reg00", en_reg_out_7_0, 8'hFF);
    wr(7'h01, 8'h0F); check("reg01", en_reg_out_15_8, 8'h0F);
    wr(7'h02, 8'hAA); check("reg02", en_reg_pwm_7_0, 8'hAA);
    wr(7'h03, 8'h55); check("reg03", en_reg_pwm_15_8, 8'h55);
    wr(7'h04, 8'h80); check("reg04", pwm_duty_cycle, 8'h80);
    wr(7'h20, 8'h00);
    check("ign00", en_reg_out_7_0, 8'hFF);
    check("ign01", en_reg_out_15_8, 8'h0F);
    check("ign02", en_reg_pwm_7_0, 8'hAA);
    check("ign03", en_reg_pwm_15_8, 8'h55);
    check("ign04", pwm_duty_cycle, 8'h80);
    check("ign_busy", fade_busy, 1'b0);

    // Basic fade 0x10 -> 0x40, step 0x10, period 1: a step every 8 clocks
    wr(7'h04, 8'h10); wr(7'h05, 8'h40); wr(7'h06, 8'h10); wr(7'h07, 8'h01);
    wr(7'h08, 8'h01);
    check("fade_busy_start", fade_busy, 1'b1);
    check("fade_duty_start", pwm_duty_cycle, 8'h10);
    for (int k = 1; k <= 26; k++) begin
      cycles(1);
      exp_duty = (k >= 24) ? 8'h40 : 8'(8'h10 + 8'h10 * (k / 8));
      check("fade_duty", pwm_duty_cycle, exp_duty);
      check("fade_done", fade_done, (k == 24));
      check("fade_busy", fade_busy, (k < 24));
    end

    // Up to 0xFF without wrap
    wr(7'h04, 8'hF8); wr(7'h05, 8'hFF); wr(7'h06, 8'h10); wr(7'h07, 8'h00);
    wr(7'h08, 8'h01);
    cycles(3); check("hi_pre", pwm_duty_cycle, 8'hF8);
    cycles(1); check("hi_duty", pwm_duty_cycle, 8'hFF);
    check("hi_done", fade_done, 1'b1);
    check("hi_busy", fade_busy, 1'b0);

    // Down to 0x00 without wrap
    wr(7'h04, 8'h05); wr(7'h05, 8'h00);
    wr(7'h08, 8'h01);
    cycles(4); check("lo_duty", pwm_duty_cycle, 8'h00);
    check("lo_done", fade_done, 1'b1);

    // Step register 0 acts as 1
    wr(7'h04, 8'h10); wr(7'h05, 8'h12); wr(7'h06, 8'h00);
    wr(7'h08, 8'h01);
    cycles(4); check("s0_a", pwm_duty_cycle, 8'h11);
    check("s0_a_done", fade_done, 1'b0);
    cycles(4); check("s0_b", pwm_duty_cycle, 8'h12);
    check("s0_b_done", fade_done, 1'b1);

    // Target equal to duty completes on the first step
    wr(7'h06, 8'h01);
    wr(7'h08, 8'h01);
    cycles(3); check("eq_pre_done", fade_done, 1'b0);
    cycles(1); check("eq_duty", pwm_duty_cycle, 8'h12);
    check("eq_done", fade_done, 1'b1);
    check("eq_busy", fade_busy, 1'b0);

    // Ping-pong loop
    wr(7'h04, 8'h00); wr(7'h05, 8'h20); wr(7'h06, 8'h10);
    wr(7'h08, 8'h03);
    cycles(4); check("loop1", pwm_duty_cycle, 8'h10); check("loop1_done", fade_done, 1'b0);
    cycles(4); check("loop2", pwm_duty_cycle, 8'h20); check("loop2_done", fade_done, 1'b1);
    check("loop2_busy", fade_busy, 1'b1);
    cycles(4); check("loop3", pwm_duty_cycle, 8'h10); check("loop3_done", fade_done, 1'b0);
    cycles(4); check("loop4", pwm_duty_cycle, 8'h00); check("loop4_done", fade_done, 1'b1);
    cycles(4); check("loop5", pwm_duty_cycle, 8'h10);
    wr(7'h08, 8'h00);
    check("stop_busy", fade_busy, 1'b0);
    check("stop_duty", pwm_duty_cycle, 8'h10);
    cycles(10);
    check("stop_hold", pwm_duty_cycle, 8'h10);
    check("stop_done", fade_done, 1'b0);

    // Host duty write on the same edge as a step event
    wr(7'h04, 8'h00); wr(7'h05, 8'h40);
    wr(7'h08, 8'h01);
    cycles(3);
    check("host_pre", pwm_duty_cycle, 8'h00);
    wr(7'h04, 8'h77);
    check("host_duty", pwm_duty_cycle, 8'h77);
    check("host_busy", fade_busy, 1'b0);
    check("host_done", fade_done, 1'b0);
    cycles(1); check("host_done2", fade_done, 1'b0);
    cycles(8); check("host_hold", pwm_duty_cycle, 8'h77);

    // Asynchronous reset mid-fade
    wr(7'h05, 8'h10); wr(7'h06, 8'h01);
    wr(7'h08, 8'h01);
    cycles(6);
    check("mid_duty", pwm_duty_cycle, 8'h76);
    #3 rst_n = 1'b0;
    #1;
    check("ar_duty", pwm_duty_cycle, 8'h00);
    check("ar_busy", fade_busy, 1'b0);
    check("ar_en0", en_reg_out_7_0, 8'h00);
    check("ar_en3", en_reg_pwm_15_8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      check("post_rst_duty", pwm_duty_cycle, 8'h00);
      check("post_rst_busy", fade_busy, 1'b0);
      check("post_rst_done", fade_done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Owns the PWM configuration register bank and drives the PWM output-enable, PWM-enable and duty-cycle inputs.
- Accepts decoded register writes from the SPI front end.
- Adds an autonomous fade engine that ramps the duty cycle toward a programmed target at a programmed rate, with optional ping-pong looping.
- Arbitrates between host writes and the fade engine for the shared duty-cycle register; the host always wins.

Parameters:
PRESCALE, 256, system clocks per prescaler tick (>=2); fade step interval is (fade_period+1)*PRESCALE clocks

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  one-cycle write strobe from SPI front end
wr_addr  input  7  register address
wr_data  input  8  register write data
en_reg_out_7_0  output  8  output enables, bits 7:0 (addr 0x00)
en_reg_out_15_8  output  8  output enables, bits 15:8 (addr 0x01)
en_reg_pwm_7_0  output  8  PWM enables, bits 7:0 (addr 0x02)
en_reg_pwm_15_8  output  8  PWM enables, bits 15:8 (addr 0x03)
pwm_duty_cycle  output  8  current duty cycle (addr 0x04; also written by fade engine)
fade_busy  output  1  high while fade FSM is in RUN
fade_done  output  1  one-cycle pulse each time duty reaches target

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs, all internal registers, counters and FSM go to 0/IDLE.
  - fade_busy=0, fade_done=0.
- Register map; writes take effect on the clock edge where wr_valid=1:
  - 0x00-0x04: direct registers, as per outputs.
  - 0x05 fade_target.
  - 0x06 fade_step; 0 is treated as 1.
  - 0x07 fade_period.
  - 0x08 fade_ctrl: bit0 start/run, bit1 loop; other bits ignored.
  - Writes to 0x09-0x7F are ignored; no state changes.
- FSM states: IDLE, RUN.
- IDLE -> RUN: a write to 0x08 with bit0=1.
  - Capture origin = current pwm_duty_cycle and the loop bit.
  - Clear prescaler and period counters.
  - fade_busy=1 from the next cycle.
- RUN, timing:
  - Prescaler counts 0..PRESCALE-1. On wrap, the period counter counts 0..fade_period.
  - On period-counter wrap a step event fires. The first step fires exactly (fade_period+1)*PRESCALE clocks after start is accepted.
- RUN, step event with d = |fade_target - pwm_duty_cycle| and s = effective step:
  - d==0 or d<=s: pwm_duty_cycle <= fade_target and fade_done pulses the following cycle. Then:
    - loop=0: go to IDLE.
    - loop=1: swap fade_target and origin, stay in RUN; counters keep running.
  - Otherwise: pwm_duty_cycle moves toward target by s.
  - Arithmetic is 9-bit internally. The result never overshoots the target and never wraps past 0 or 255.
- Start with target == current duty: the first step event completes immediately; no duty change.
- RUN -> IDLE by a write to 0x08 with bit0=0:
  - Duty holds its current value; no fade_done.
  - fade_busy falls the next cycle.
- Host write to 0x04 during RUN:
  - Host value is loaded into duty, the fade aborts to IDLE, and no fade_done.
  - If a step event coincides on the same edge, the host value wins and the step is discarded.
- Host write to 0x05/0x06/0x07 during RUN: takes effect for the next step event. Counters are not reset.
- Write to 0x08 with bit0=1 during RUN: restart. Recapture origin and loop bit, and clear counters.
- Writes to 0x00-0x03 never affect the fade engine.
- Reset mid-fade: immediate IDLE with all registers zero; no done pulse.

Test Plan (PRESCALE=4):
- Reset, then write 0x00..0x04 = 0xFF,0x0F,0xAA,0x55,0x80 -> outputs match one cycle after each strobe; write to 0x20 changes nothing.
- Duty=0x10, target=0x40, step=0x10, period=1, ctrl=0x01 -> duty steps to 0x20,0x30,0x40 every 8 clocks, first step 8 clocks after start; fade_done pulses once; fade_busy drops.
- Duty=0xF8, target=0xFF, step=0x10 -> a single step lands exactly at 0xFF, no wrap. Duty=0x05, target=0x00, step=0x10 -> 0x00.
- Loop: duty=0x00, target=0x20, step=0x10, ctrl=0x03 -> 0x10,0x20 (done), 0x10,0x00 (done), 0x10 ...; ctrl=0x00 freezes duty, busy=0.
- During RUN, host writes 0x04=0x77 on the same edge as a step event -> duty=0x77, busy=0 next cycle, no fade_done.
- Assert rst_n low mid-fade at an arbitrary phase -> all outputs 0 immediately; after release the FSM is IDLE and no step occurs.
